alarm_controller: RTL and testbench
===================================

ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter SNOOZE_MIN, default 9: snooze length in minutes (1-30).
REQ-002 Parameter RING_TIMEOUT_S, default 60: seconds of ringing before auto-silence (1-255).
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event (1-15).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tick  in  1  one-cycle pulse per second; same strobe that drives the time-keeping stage's ena.
REQ-007 pm, hh, mm, ss  in  1/8/8/8  current time from the 12-hour time-keeping stage; hh 01-12, mm/ss 00-59, packed BCD with tens digit in [7:4].
REQ-008 arm  in  1  level; 1 = alarm enabled.
REQ-009 set_en  in  1  one-cycle request to load the alarm time from set_pm/set_hh/set_mm.
REQ-010 set_pm, set_hh, set_mm  in  1/8/8  candidate alarm time, BCD.
REQ-011 snooze, stop  in  1/1  one-cycle user pulses.
REQ-012 ring  out  1  registered; 1 while in RINGING.
REQ-013 alarm_pm, alarm_hh, alarm_mm  out  1/8/8  stored alarm time.
REQ-014 state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-015 snooze_cnt  out  4  snoozes used in the current alarm event.
REQ-016 set_err  out  1  one-cycle pulse on a rejected set request.

Function
REQ-017 Alarm-time load: set_en with set_hh in 01-12, set_mm in 00-59 and both BCD digits ≤9 SHALL load all three alarm registers on that edge; otherwise no register changes and set_err is high for exactly the next cycle.
REQ-018 An accepted set_en in RINGING or SNOOZE SHALL move to ARMED (if arm=1) and clear snooze_cnt.
REQ-019 Match SHALL be true on a cycle with tick=1, ss=8'h00, hh=alarm_hh, mm=alarm_mm and pm=alarm_pm; inputs are sampled on the tick cycle.
REQ-020 IDLE: arm=1 -> ARMED next edge.
REQ-021 ARMED: match -> RINGING; ring high starting the cycle after the match cycle (1-cycle latency); ring timer cleared.
REQ-022 RINGING: each tick increments the ring timer; the tick that brings it to RING_TIMEOUT_S -> ARMED with snooze_cnt cleared.
REQ-023 RINGING: snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, countdown loaded with SNOOZE_MIN*60; with snooze_cnt=MAX_SNOOZE the snooze is ignored.
REQ-024 SNOOZE: each tick decrements the countdown; the tick that takes it from 1 to 0 -> RINGING with ring timer cleared; snooze_cnt kept.
REQ-025 stop in RINGING or SNOOZE -> ARMED with snooze_cnt cleared; stop in IDLE or ARMED has no effect.
REQ-026 arm=0 in any state -> IDLE next edge, with snooze_cnt, ring timer and countdown cleared; alarm time retained.
REQ-027 Priority on a single edge: reset > arm=0 > stop > snooze > timeout/countdown expiry/match; set_en is evaluated in parallel with these, and REQ-018 yields to arm=0.
REQ-028 Match SHALL be ignored in RINGING and SNOOZE; a match on the same tick as a timeout SHALL not re-trigger ringing until the next matching minute.
REQ-029 Counters SHALL be sized by $clog2 of their maximum and SHALL never wrap.

Reset
REQ-030 reset SHALL force state=IDLE, ring=0, snooze_cnt=0, set_err=0, ring timer=0, countdown=0, alarm_pm=0, alarm_hh=8'h12, alarm_mm=8'h00 (12:00 AM), taking effect even mid-ring or mid-snooze.
REQ-031 reset SHALL override arm, set_en, snooze and stop on the same edge.

Verification
REQ-032 Set 06:30 AM, arm=1, drive 06:29:59 AM then 06:30:00 AM with tick -> ring=1 the cycle after the 06:30:00 tick, state=2.
REQ-033 Use SNOOZE_MIN=1. Ringing, pulse snooze -> state=3, snooze_cnt=1, ring=0; after 60 ticks -> ring=1; repeat until snooze_cnt=3, then a 4th snooze is ignored and ring stays 1.
REQ-034 Ringing, no input, 60 ticks -> state=1, ring=0, snooze_cnt=0; the same 06:30:00 PM input does not match (pm mismatch).
REQ-035 set_hh=8'h13 or set_mm=8'h5A -> set_err pulses 1 cycle and alarm registers are unchanged; set_hh=8'h12 with set_pm=1 is accepted.
REQ-036 Ringing, assert stop and snooze on the same cycle -> ARMED; deassert arm during SNOOZE -> IDLE; assert reset during RINGING -> all REQ-030 values on the next cycle.

Source files
------------

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm clock controller: alarm time store, match, ring timeout, snooze countdown
module alarm_controller #(
   parameter int SNOOZE_MIN     = 9,
   parameter int RING_TIMEOUT_S = 60,
   parameter int MAX_SNOOZE     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       pm,
   input  logic [7:0] hh,
   input  logic [7:0] mm,
   input  logic [7:0] ss,
   input  logic       arm,
   input  logic       set_en,
   input  logic       set_pm,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic       snooze,
   input  logic       stop,
   output logic       ring,
   output logic       alarm_pm,
   output logic [7:0] alarm_hh,
   output logic [7:0] alarm_mm,
   output logic [1:0] state,
   output logic [3:0] snooze_cnt,
   output logic       set_err
);
   localparam int SNOOZE_S = SNOOZE_MIN * 60;
   localparam int RT_W     = $clog2(RING_TIMEOUT_S + 1);
   localparam int CD_W     = $clog2(SNOOZE_S + 1);
   localparam logic [RT_W-1:0] RT_LAST  = RT_W'(RING_TIMEOUT_S - 1);
   localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(SNOOZE_S);
   localparam logic [3:0]      SNZ_MAX  = 4'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_RINGING = 2'd2,
      S_SNOOZE  = 2'd3
   } state_t;

   state_t          r_state, w_state_nx;
   logic [3:0]      r_snooze_cnt, w_snooze_cnt_nx;
   logic [RT_W-1:0] r_ring_t, w_ring_t_nx;
   logic [CD_W-1:0] r_cd, w_cd_nx;
   logic            r_ring, r_set_err, r_alarm_pm;
   logic [7:0]      r_alarm_hh, r_alarm_mm;
   logic            w_hh_ok, w_mm_ok, w_set_ok, w_match;

   // Hour must be 01-09 or 10-12 in BCD; minute 00-59.
   assign w_hh_ok  = (set_hh[7:4] == 4'd0 && set_hh[3:0] >= 4'd1 && set_hh[3:0] <= 4'd9) ||
                     (set_hh[7:4] == 4'd1 && set_hh[3:0] <= 4'd2);
   assign w_mm_ok  = (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9);
   assign w_set_ok = w_hh_ok && w_mm_ok;
   assign w_match  = tick && (ss == 8'h00) && (hh == r_alarm_hh) &&
                     (mm == r_alarm_mm) && (pm == r_alarm_pm);

   always_comb begin
      w_state_nx      = r_state;
      w_snooze_cnt_nx = r_snooze_cnt;
      w_ring_t_nx     = r_ring_t;
      w_cd_nx         = r_cd;
      if (!arm) begin
         w_state_nx      = S_IDLE;
         w_snooze_cnt_nx = 4'd0;
         w_ring_t_nx     = '0;
         w_cd_nx         = '0;
      end else begin
         unique case (r_state)
            S_IDLE: w_state_nx = S_ARMED;
            S_ARMED: begin
               if (w_match) begin
                  w_state_nx  = S_RINGING;
                  w_ring_t_nx = '0;
               end
            end
            S_RINGING: begin
               if (stop) begin
                  w_state_nx      = S_ARMED;
                  w_snooze_cnt_nx = 4'd0;
               end else if (snooze && r_snooze_cnt < SNZ_MAX) begin
                  w_state_nx      = S_SNOOZE;
                  w_snooze_cnt_nx = r_snooze_cnt + 4'd1;
                  w_cd_nx         = CD_LOAD;
               end else if (tick) begin
                  if (r_ring_t == RT_LAST) begin
                     w_state_nx      = S_ARMED;
                     w_snooze_cnt_nx = 4'd0;
                     w_ring_t_nx     = '0;
                  end else begin
                     w_ring_t_nx = r_ring_t + 1'b1;
                  end
               end
            end
            S_SNOOZE: begin
               if (stop) begin
                  w_state_nx      = S_ARMED;
                  w_snooze_cnt_nx = 4'd0;
                  w_cd_nx         = '0;
               end else if (tick) begin
                  if (r_cd <= CD_W'(1)) begin
                     w_state_nx  = S_RINGING;
                     w_ring_t_nx = '0;
                     w_cd_nx     = '0;
                  end else begin
                     w_cd_nx = r_cd - 1'b1;
                  end
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
         // A fresh alarm time abandons the current alarm event.
         if (set_en && w_set_ok && (r_state == S_RINGING || r_state == S_SNOOZE)) begin
            w_state_nx      = S_ARMED;
            w_snooze_cnt_nx = 4'd0;
            w_ring_t_nx     = '0;
            w_cd_nx         = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_snooze_cnt <= 4'd0;
         r_ring_t     <= '0;
         r_cd         <= '0;
         r_ring       <= 1'b0;
         r_set_err    <= 1'b0;
         r_alarm_pm   <= 1'b0;
         r_alarm_hh   <= 8'h12;
         r_alarm_mm   <= 8'h00;
      end else begin
         r_state      <= w_state_nx;
         r_snooze_cnt <= w_snooze_cnt_nx;
         r_ring_t     <= w_ring_t_nx;
         r_cd         <= w_cd_nx;
         r_ring       <= (w_state_nx == S_RINGING);
         r_set_err    <= set_en && !w_set_ok;
         if (set_en && w_set_ok) begin
            r_alarm_pm <= set_pm;
            r_alarm_hh <= set_hh;
            r_alarm_mm <= set_mm;
         end
      end
   end

   assign ring       = r_ring;
   assign state      = r_state;
   assign snooze_cnt = r_snooze_cnt;
   assign set_err    = r_set_err;
   assign alarm_pm   = r_alarm_pm;
   assign alarm_hh   = r_alarm_hh;
   assign alarm_mm   = r_alarm_mm;
endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;
   logic       clk = 1'b0;
   logic       reset, tick, pm, arm, set_en, set_pm, snooze, stop;
   logic [7:0] hh, mm, ss, set_hh, set_mm;
   logic       ring, alarm_pm, set_err;
   logic [7:0] alarm_hh, alarm_mm;
   logic [1:0] state;
   logic [3:0] snooze_cnt;
   int         n_checks = 0;
   int         n_errors = 0;

   alarm_controller #(.SNOOZE_MIN(1), .RING_TIMEOUT_S(60), .MAX_SNOOZE(3)) dut (
      .clk(clk), .reset(reset), .tick(tick), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
      .arm(arm), .set_en(set_en), .set_pm(set_pm), .set_hh(set_hh), .set_mm(set_mm),
      .snooze(snooze), .stop(stop), .ring(ring), .alarm_pm(alarm_pm),
      .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .state(state),
      .snooze_cnt(snooze_cnt), .set_err(set_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; pulse inputs are dropped after the edge, outputs are then stable.
   task automatic cyc();
      @(posedge clk);
      #1;
      tick = 1'b0; set_en = 1'b0; snooze = 1'b0; stop = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cyc();
      end
   endtask

   task automatic set_time(input logic p, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      pm = p; hh = h; mm = m; ss = s;
   endtask

   task automatic load(input logic p, input logic [7:0] h, input logic [7:0] m);
      set_en = 1'b1; set_pm = p; set_hh = h; set_mm = m;
      cyc();
   endtask

   initial begin
      reset = 1'b1; tick = 0; arm = 0; set_en = 0; snooze = 0; stop = 0;
      set_pm = 0; set_hh = 8'h00; set_mm = 8'h00;
      set_time(1'b0, 8'h01, 8'h00, 8'h10);
      cyc();
      cyc();
      reset = 1'b0;
      check("rst_state", state, 2'd0);
      check("rst_ring", ring, 1'b0);
      check("rst_cnt", snooze_cnt, 4'd0);
      check("rst_err", set_err, 1'b0);
      check("rst_hh", alarm_hh, 8'h12);
      check("rst_mm", alarm_mm, 8'h00);
      check("rst_pm", alarm_pm, 1'b0);

      load(1'b0, 8'h06, 8'h30);
      check("set_hh", alarm_hh, 8'h06);
      check("set_mm", alarm_mm, 8'h30);
      check("set_ok_err", set_err, 1'b0);
      check("idle_unarmed", state, 2'd0);

      arm = 1'b1;
      cyc();
      check("armed", state, 2'd1);
      stop = 1'b1;
      cyc();
      check("stop_in_armed", state, 2'd1);

      set_time(1'b0, 8'h06, 8'h29, 8'h59);
      ticks(1);
      check("pre_match_ring", ring, 1'b0);
      set_time(1'b0, 8'h06, 8'h30, 8'h00);
      ticks(1);
      check("match_ring", ring, 1'b1);
      check("match_state", state, 2'd2);

      set_time(1'b0, 8'h06, 8'h30, 8'h05);
      for (int k = 1; k <= 3; k++) begin
         snooze = 1'b1;
         cyc();
         check("snz_state", state, 2'd3);
         check("snz_cnt", snooze_cnt, 4'(k));
         check("snz_ring", ring, 1'b0);
         ticks(59);
         check("snz_59", ring, 1'b0);
         ticks(1);
         check("snz_60_ring", ring, 1'b1);
         check("snz_60_state", state, 2'd2);
      end
      snooze = 1'b1;
      cyc();
      check("snz4_state", state, 2'd2);
      check("snz4_ring", ring, 1'b1);
      check("snz4_cnt", snooze_cnt, 4'd3);

      ticks(59);
      check("to_59_state", state, 2'd2);
      ticks(1);
      check("to_state", state, 2'd1);
      check("to_ring", ring, 1'b0);
      check("to_cnt", snooze_cnt, 4'd0);
      set_time(1'b1, 8'h06, 8'h30, 8'h00);
      ticks(1);
      check("pm_nomatch", state, 2'd1);

      load(1'b0, 8'h13, 8'h00);
      check("bad_hh_err", set_err, 1'b1);
      check("bad_hh_keep", alarm_hh, 8'h06);
      cyc();
      check("err_one_cycle", set_err, 1'b0);
      load(1'b0, 8'h07, 8'h5A);
      check("bad_mm_err", set_err, 1'b1);
      check("bad_mm_keep", alarm_mm, 8'h30);
      check("bad_mm_hh_keep", alarm_hh, 8'h06);
      load(1'b1, 8'h12, 8'h00);
      check("pm12_err", set_err, 1'b0);
      check("pm12_pm", alarm_pm, 1'b1);
      check("pm12_hh", alarm_hh, 8'h12);

      set_time(1'b1, 8'h12, 8'h00, 8'h00);
      ticks(1);
      check("pm_match", state, 2'd2);
      stop = 1'b1; snooze = 1'b1;
      cyc();
      check("stop_snz_state", state, 2'd1);
      check("stop_snz_cnt", snooze_cnt, 4'd0);

      ticks(1);
      snooze = 1'b1;
      cyc();
      check("snz_again", state, 2'd3);
      arm = 1'b0;
      cyc();
      check("disarm_state", state, 2'd0);
      check("disarm_cnt", snooze_cnt, 4'd0);
      check("disarm_keep_hh", alarm_hh, 8'h12);
      check("disarm_keep_pm", alarm_pm, 1'b1);

      arm = 1'b1;
      cyc();
      ticks(1);
      check("ring_before_rst", ring, 1'b1);
      reset = 1'b1; snooze = 1'b1; stop = 1'b1;
      set_en = 1'b1; set_hh = 8'h13;
      cyc();
      reset = 1'b0;
      check("rr_state", state, 2'd0);
      check("rr_ring", ring, 1'b0);
      check("rr_cnt", snooze_cnt, 4'd0);
      check("rr_err", set_err, 1'b0);
      check("rr_hh", alarm_hh, 8'h12);
      check("rr_mm", alarm_mm, 8'h00);
      check("rr_pm", alarm_pm, 1'b0);

      cyc();
      set_time(1'b0, 8'h12, 8'h00, 8'h00);
      ticks(1);
      check("am12_ring", state, 2'd2);
      load(1'b0, 8'h07, 8'h15);
      check("set_in_ring_state", state, 2'd1);
      check("set_in_ring_hh", alarm_hh, 8'h07);
      check("set_in_ring_ring", ring, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
